accum_sequencer: RTL and testbench
==================================

// Module: accum_sequencer
// PURPOSE
//  Control sequencer for the button-driven accumulator datapath (step counter, adder, accumulator register).
//  Each synchronised button press adds the current step (0..STEP_MAX) into the accumulator, then advances the step.
//  It then converts the result to two BCD digits for the seven-segment decoders with a multi-cycle shift-add-3 FSM.
//  Sits between the board button/clock and the hex display path; owns all datapath sequencing.
// PARAMETERS
//  DATA_W   6   accumulator width; legal 1..6 (result must fit two BCD digits, max 63)
//  STEP_MAX 10  last step value; step counts 0..STEP_MAX then wraps to 0; legal 1..15
//  BTN_SYNC 2   synchroniser flops on btn; legal >=2
// PORTS
//  clk    in   1       system clock, all state on rising edge
//  reset  in   1       asynchronous, active-low reset
//  btn    in   1       raw push-button, asynchronous to clk, active-high
//  clr    in   1       synchronous clear, active-high
//  acc_q  out  DATA_W  accumulator value
//  step   out  4       step value the next press will add
//  tens   out  4       BCD tens digit of last converted acc_q
//  ones   out  4       BCD ones digit of last converted acc_q
//  busy   out  1       high while state != IDLE
//  ovf    out  1       sticky overflow flag
// BEHAVIOUR
//  Reset (reset==0, async): acc_q=0, step=0, tens=0, ones=0, ovf=0, busy=0, pend=0, state=IDLE, sync flops=0.
//  Edge detect: btn passes BTN_SYNC flops; edge = sync_out & ~sync_out_d. Exactly one edge per 0->1 transition.
//  FSM states: IDLE, ADD, CONV.
//   IDLE: edge or pend -> ADD (pend cleared); else stay.
//   ADD (1 cycle): acc_q <= acc_q + step; step <= (step==STEP_MAX) ? 0 : step+1; -> CONV.
//   CONV: DATA_W cycles of double-dabble on a shadow copy of acc_q.
//    On last cycle, tens/ones <= result -> IDLE.
//  Timing: edge at cycle E -> ADD at E+1 -> new acc_q visible at E+2.
//   CONV occupies E+2..E+1+DATA_W; tens/ones valid and busy=0 at E+2+DATA_W.
//  tens/ones hold the previous value throughout ADD/CONV (no partial results ever visible).
//  Edge while busy: pend<=1 (depth-1 queue); further edges while pend=1 are dropped.
//  Add width: compute DATA_W+1 bits. If carry out: acc_q <= low DATA_W bits (wrap), ovf<=1.
//   ovf stays 1 until clr or reset.
//  clr: highest synchronous priority, any state. Next cycle: acc_q=0, step=0, tens=ones=0, ovf=0, pend=0, state=IDLE.
//   An edge in the same cycle as clr is discarded.
//  Reset mid-ADD/CONV: async; all outputs go to reset values immediately; no partial update survives.
// CONFIGURATION
//  ACC_SAT_EN defined: on carry out, acc_q <= 2^DATA_W-1 (saturate), ovf<=1; later adds keep it saturated.
//  ACC_SAT_EN undefined: wrap-around as above. Timing identical in both builds.
// TESTING
//  T1: reset, 4 presses spaced >DATA_W+4 cycles -> adds 0,1,2,3; acc_q=6, step=4, tens=0, ones=6, ovf=0.
//  T2: reset, 11 presses -> acc_q=55, step=0 (wrapped), tens=5, ones=5, ovf=0.
//  T3: from T2, 5 more presses (add 0,1,2,3,4) -> sum 65.
//   Default: acc_q=1, tens=0, ones=1, ovf=1. ACC_SAT_EN: acc_q=63, tens=6, ones=3, ovf=1.
//  T4: reset, press once, then 2 further edges during CONV.
//   -> exactly 2 adds total: acc_q=1, step=2, busy low 2*(DATA_W+2) cycles after the first edge.
//  T5: acc_q=6 and mid-CONV, pulse clr 1 cycle -> next cycle acc_q=0, step=0, tens=ones=0, ovf=0, busy=0; no pending add.
//  T6: assert reset during ADD, asynchronously -> all outputs 0 before next clk edge.
//   Release reset, 1 press -> acc_q=0, step=1.

Source files
------------

// File: rtl/accum_sequencer.sv
// accum_sequencer: button-driven step accumulator with multi-cycle binary-to-BCD conversion.
// Build option ACC_SAT_EN saturates the accumulator on overflow instead of wrapping.
module accum_sequencer #(
    parameter int DATA_W   = 6,
    parameter int STEP_MAX = 10,
    parameter int BTN_SYNC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn,
    input  logic              clr,
    output logic [DATA_W-1:0] acc_q,
    output logic [3:0]        step,
    output logic [3:0]        tens,
    output logic [3:0]        ones,
    output logic              busy,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, ADD, CONV} state_t;
    state_t state_q, state_d;
    logic [BTN_SYNC-1:0] sync_q;
    logic sync_prev_q, btn_edge, pend_q, pend_d, ovf_q, ovf_d, carry;
    logic [DATA_W-1:0] acc_d, acc_next, bin_q, bin_d;
    logic [DATA_W+4:0] sum_w;
    logic [3:0] step_q, step_d, tens_q, tens_d, ones_q, ones_d, lo_adj;
    logic [5:0] bcd_q, bcd_d;
    logic [6:0] bcd_shift;
    logic [2:0] cnt_q, cnt_d;

    assign btn_edge = sync_q[BTN_SYNC-1] & ~sync_prev_q;
    assign sum_w    = {5'b0, acc_q} + {{(DATA_W+1){1'b0}}, step_q};
    assign carry    = |sum_w[DATA_W+4:DATA_W];
`ifdef ACC_SAT_EN
    assign acc_next = carry ? '1 : sum_w[DATA_W-1:0];
`else
    assign acc_next = sum_w[DATA_W-1:0];
`endif
    // Result is below 100, so the tens digit never reaches 5 before a shift and needs no add-3.
    assign lo_adj    = bcd_q[3:0] + ((bcd_q[3:0] >= 4'd5) ? 4'd3 : 4'd0);
    assign bcd_shift = {bcd_q[5:4], lo_adj, bin_q[DATA_W-1]};
    assign step = step_q;
    assign tens = tens_q;
    assign ones = ones_q;
    assign ovf  = ovf_q;
    assign busy = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            step_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
            ovf_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (btn_edge || pend_q) begin
                    state_d = ADD;
                    pend_d  = 1'b0;
                end
                ADD: begin
                    acc_d   = acc_next;
                    ovf_d   = ovf_q | carry;
                    step_d  = (step_q == 4'(STEP_MAX)) ? 4'd0 : step_q + 4'd1;
                    bin_d   = acc_next;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    pend_d  = pend_q | btn_edge;
                    state_d = CONV;
                end
                default: begin
                    bin_d  = bin_q << 1;
                    bcd_d  = bcd_shift[5:0];
                    cnt_d  = cnt_q + 3'd1;
                    pend_d = pend_q | btn_edge;
                    if (cnt_q == 3'(DATA_W - 1)) begin
                        tens_d  = {1'b0, bcd_shift[6:4]};
                        ones_d  = bcd_shift[3:0];
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            acc_q       <= '0;
            step_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[BTN_SYNC-2:0], btn};
            sync_prev_q <= sync_q[BTN_SYNC-1];
            acc_q       <= acc_d;
            step_q      <= step_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed scenario tasks for accum_sequencer with hand-computed expectations.
module tb_accum_sequencer;
    logic clk = 1'b0, reset = 1'b1, btn = 1'b0, clr = 1'b0;
    logic [5:0] acc_q;
    logic [3:0] step, tens, ones;
    logic busy, ovf;
    int total = 0, bad = 0;

`ifdef ACC_SAT_EN
    localparam logic [5:0] T3_ACC = 6'd63, X_ACC = 6'd63;
    localparam logic [3:0] T3_TENS = 4'd6, T3_ONES = 4'd3, X_TENS = 4'd6, X_ONES = 4'd3;
`else
    localparam logic [5:0] T3_ACC = 6'd1, X_ACC = 6'd6;
    localparam logic [3:0] T3_TENS = 4'd0, T3_ONES = 4'd1, X_TENS = 4'd0, X_ONES = 4'd6;
`endif

    accum_sequencer dut (
        .clk(clk), .reset(reset), .btn(btn), .clr(clr), .acc_q(acc_q),
        .step(step), .tens(tens), .ones(ones), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        btn = 1'b0;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic press;
        @(negedge clk);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        total++; if ({acc_q, step, tens, ones, busy, ovf} !== 22'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {acc_q, step, tens, ones, busy, ovf}); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_t1;
        do_reset();
        press();
        @(negedge clk);
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) btn = 1'b0;
            if (k == 3) begin
                total++; if (acc_q !== 6'd0 || busy !== 1'b1) begin bad++; $display("FAIL t1_add_cycle acc=%0d busy=%b want acc=0 busy=1", acc_q, busy); end
            end
            if (k == 4) begin
                total++; if (acc_q !== 6'd1 || ones !== 4'd0) begin bad++; $display("FAIL t1_acc_visible acc=%0d ones=%0d want acc=1 ones=0", acc_q, ones); end
            end
            if (k == 9) begin
                total++; if (busy !== 1'b1 || ones !== 4'd0) begin bad++; $display("FAIL t1_conv_hold busy=%b ones=%0d want busy=1 ones=0", busy, ones); end
            end
            if (k == 10) begin
                total++; if (busy !== 1'b0 || ones !== 4'd1 || tens !== 4'd0) begin bad++; $display("FAIL t1_conv_done busy=%b tens=%0d ones=%0d want 0,0,1", busy, tens, ones); end
            end
        end
        repeat (4) @(negedge clk);
        press();
        press();
        total++; if (acc_q !== 6'd6 || step !== 4'd4) begin bad++; $display("FAIL t1_final acc=%0d step=%0d want acc=6 step=4", acc_q, step); end
        total++; if (tens !== 4'd0 || ones !== 4'd6 || ovf !== 1'b0) begin bad++; $display("FAIL t1_bcd tens=%0d ones=%0d ovf=%b want 0,6,0", tens, ones, ovf); end
    endtask

    task automatic test_wrap_ovf;
        do_reset();
        repeat (11) press();
        total++; if (acc_q !== 6'd55 || step !== 4'd0) begin bad++; $display("FAIL t2_acc acc=%0d step=%0d want acc=55 step=0", acc_q, step); end
        total++; if (tens !== 4'd5 || ones !== 4'd5 || ovf !== 1'b0) begin bad++; $display("FAIL t2_bcd tens=%0d ones=%0d ovf=%b want 5,5,0", tens, ones, ovf); end
        repeat (5) press();
        total++; if (acc_q !== T3_ACC || ovf !== 1'b1 || step !== 4'd5) begin bad++; $display("FAIL t3_acc acc=%0d ovf=%b step=%0d want acc=%0d ovf=1 step=5", acc_q, ovf, step, T3_ACC); end
        total++; if (tens !== T3_TENS || ones !== T3_ONES) begin bad++; $display("FAIL t3_bcd tens=%0d ones=%0d want %0d,%0d", tens, ones, T3_TENS, T3_ONES); end
        press();
        total++; if (acc_q !== X_ACC || ovf !== 1'b1 || tens !== X_TENS || ones !== X_ONES) begin bad++; $display("FAIL ovf_sticky acc=%0d ovf=%b tens=%0d ones=%0d want acc=%0d ovf=1", acc_q, ovf, tens, ones, X_ACC); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        @(negedge clk);
        btn = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            btn = (k < 6 && k % 2 == 0);
            if (k == 17) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL t4_busy_late busy=%b want 1", busy); end
            end
            if (k == 18) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_busy_low busy=%b want 0", busy); end
            end
        end
        repeat (20) @(negedge clk);
        total++; if (acc_q !== 6'd1 || step !== 4'd2 || ones !== 4'd1) begin bad++; $display("FAIL t4_two_adds acc=%0d step=%0d ones=%0d want 1,2,1", acc_q, step, ones); end
    endtask

    task automatic test_clr;
        do_reset();
        repeat (3) press();
        @(negedge clk);
        btn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            btn = (k == 2);
            if (k == 6) begin
                total++; if (acc_q !== 6'd6 || busy !== 1'b1) begin bad++; $display("FAIL t5_pre_clr acc=%0d busy=%b want 6,1", acc_q, busy); end
                clr = 1'b1;
            end
            if (k == 7) begin
                clr = 1'b0;
                total++; if ({acc_q, step, tens, ones, busy, ovf} !== 22'd0) begin bad++; $display("FAIL t5_clr got=%h want=0", {acc_q, step, tens, ones, busy, ovf}); end
            end
        end
        repeat (20) @(negedge clk);
        total++; if (acc_q !== 6'd0 || step !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL t5_no_pend acc=%0d step=%0d busy=%b want 0,0,0", acc_q, step, busy); end
    endtask

    task automatic test_async_reset;
        do_reset();
        press();
        press();
        @(negedge clk);
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1 || step !== 4'd2 || ones !== 4'd1) begin bad++; $display("FAIL t6_in_add busy=%b step=%0d ones=%0d want 1,2,1", busy, step, ones); end
        #2 reset = 1'b0;
        #1;
        total++; if ({acc_q, step, tens, ones, busy, ovf} !== 22'd0) begin bad++; $display("FAIL t6_async got=%h want=0", {acc_q, step, tens, ones, busy, ovf}); end
        @(negedge clk);
        reset = 1'b1;
        press();
        total++; if (acc_q !== 6'd0 || step !== 4'd1) begin bad++; $display("FAIL t6_after acc=%0d step=%0d want 0,1", acc_q, step); end
    endtask

    initial begin
        test_reset();
        test_basic_t1();
        test_wrap_ovf();
        test_back_to_back();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
